bbf_op_arbiter: RTL and testbench

- Shares one set of double-precision black-box float operators (BBFAdd, BBFSubtract, BBFMultiply, BBFDivide, BBFGreaterThan, BBFLessThan, BBFEquals) among N_REQ requesters.
- Uses round-robin arbitration.
- Registers each result through a LATENCY-deep pipeline, tagged with the requester id.
- Sits between real-valued simulation models of DSP blocks and the float operators, so one operator set serves a whole simulated datapath.

---
 rtl/bbf_op_arbiter.sv | 142 ++++++++++++++
 tb/tb_bbf_op_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbf_op_arbiter.sv
// bbf_op_arbiter: shares one double-precision float operator set among N_REQ requesters.
// Round-robin grant, LATENCY-deep stall-all result pipeline. `define BBF_ARB_STATS_EN adds stat_grants.
module bbf_op_arbiter #(
  parameter int N_REQ   = 4,
  parameter int LATENCY = 2,
  parameter int ID_W    = $clog2(N_REQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  output logic [N_REQ-1:0]      req_ready,
  input  logic [3*N_REQ-1:0]    req_op,
  input  logic [64*N_REQ-1:0]   req_a,
  input  logic [64*N_REQ-1:0]   req_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [ID_W-1:0]       resp_id,
  output logic [63:0]           resp_data,
  output logic                  resp_err
`ifdef BBF_ARB_STATS_EN
  ,
  output logic [32*N_REQ-1:0]   stat_grants
`endif
);

  localparam int          CW      = ID_W + 1;
  localparam logic [63:0] FP_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] FP_ZERO = 64'h0;

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] winner;
  logic            found;
  logic            advance;
  logic            handshake;
  logic [2:0]      w_op;
  logic [63:0]     w_a;
  logic [63:0]     w_b;
  logic [63:0]     w_data;
  logic            w_err;
  real             ra;
  real             rb;

  logic            stg_valid [LATENCY];
  logic [ID_W-1:0] stg_id    [LATENCY];
  logic [63:0]     stg_data  [LATENCY];
  logic            stg_err   [LATENCY];

  assign advance = !stg_valid[LATENCY-1] || resp_ready;

  // First valid requester at or above the pointer, wrapping past N_REQ-1.
  always_comb begin : arbitrate
    logic [CW-1:0] cand;
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = CW'(rr_ptr) + CW'(k);
      if (cand >= CW'(N_REQ)) cand = cand - CW'(N_REQ);
      if (!found && req_valid[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin : grant
    req_ready = '0;
    if (found && !reset) req_ready[winner] = advance;
  end

  assign handshake = found && advance && !reset;

  always_comb begin : operand_mux
    w_op = req_op[3*int'(winner) +: 3];
    w_a  = req_a[64*int'(winner) +: 64];
    w_b  = req_b[64*int'(winner) +: 64];
  end

  // Float operators; IEEE semantics (inf/NaN, unordered compares false) come from the real type.
  always_comb begin : operate
    ra     = $bitstoreal(w_a);
    rb     = $bitstoreal(w_b);
    w_data = FP_ZERO;
    w_err  = 1'b0;
    case (w_op)
      3'd0:    w_data = $realtobits(ra + rb);
      3'd1:    w_data = $realtobits(ra - rb);
      3'd2:    w_data = $realtobits(ra * rb);
      3'd3:    w_data = $realtobits(ra / rb);
      3'd4:    w_data = (ra > rb)  ? FP_ONE : FP_ZERO;
      3'd5:    w_data = (ra < rb)  ? FP_ONE : FP_ZERO;
      3'd6:    w_data = (ra == rb) ? FP_ONE : FP_ZERO;
      default: w_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        stg_valid[i] <= 1'b0;
        stg_id[i]    <= '0;
        stg_data[i]  <= '0;
        stg_err[i]   <= 1'b0;
      end
    end else if (advance) begin
      stg_valid[0] <= handshake;
      stg_id[0]    <= winner;
      stg_data[0]  <= w_data;
      stg_err[0]   <= w_err;
      for (int i = 1; i < LATENCY; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_id[i]    <= stg_id[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_err[i]   <= stg_err[i-1];
      end
      if (handshake) rr_ptr <= (winner == ID_W'(N_REQ-1)) ? '0 : winner + 1'b1;
    end
  end

  assign resp_valid = stg_valid[LATENCY-1];
  assign resp_id    = stg_id[LATENCY-1];
  assign resp_data  = stg_data[LATENCY-1];
  assign resp_err   = stg_err[LATENCY-1];

`ifdef BBF_ARB_STATS_EN
  logic [31:0] grant_cnt [N_REQ];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_REQ; i++) grant_cnt[i] <= '0;
    end else if (handshake && grant_cnt[winner] != 32'hFFFF_FFFF) begin
      grant_cnt[winner] <= grant_cnt[winner] + 32'd1;
    end
  end

  for (genvar g = 0; g < N_REQ; g++) begin : g_stat
    assign stat_grants[32*g +: 32] = grant_cnt[g];
  end
`endif

endmodule

// File: tb/tb_bbf_op_arbiter.sv
// Bench for bbf_op_arbiter: constant vector table, directed arbitration/stall/reset
// sequences, and a randomized run scored against a queue-free spec-level model.
module tb_bbf_op_arbiter;

  localparam int N   = 4;
  localparam int LAT = 2;
  localparam int IW  = 2;
  localparam logic [63:0] D1   = 64'h3FF0000000000000;
  localparam logic [63:0] D2   = 64'h4000000000000000;
  localparam logic [63:0] D3   = 64'h4008000000000000;
  localparam logic [63:0] D0   = 64'h0;
  localparam logic [63:0] DNAN = 64'h7FF8000000000000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [3*N-1:0]   req_op = '0;
  logic [64*N-1:0]  req_a = '0;
  logic [64*N-1:0]  req_b = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [IW-1:0]    resp_id;
  logic [63:0]      resp_data;
  logic             resp_err;
`ifdef BBF_ARB_STATS_EN
  logic [32*N-1:0]  stat_grants;
`endif

  bbf_op_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err)
`ifdef BBF_ARB_STATS_EN
    , .stat_grants(stat_grants)
`endif
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [2:0]  op_r [N];
  logic [63:0] a_r  [N];
  logic [63:0] b_r  [N];

  // Reference: pipeline slots as plain arrays, pointer as an integer.
  logic        m_v [LAT];
  int          m_id [LAT];
  logic [63:0] m_d [LAT];
  logic        m_e [LAT];
  int          m_ptr;
  logic        adv;
  int          g_w;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] data;
    logic        err;
  } vec_t;

  vec_t        vecs [12];
  logic [63:0] pool [8];

  function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    real x, y;
    x = $bitstoreal(a);
    y = $bitstoreal(b);
    case (op)
      3'd0: return $realtobits(x + y);
      3'd1: return $realtobits(x - y);
      3'd2: return $realtobits(x * y);
      3'd3: return $realtobits(x / y);
      3'd4: return (x > y)  ? D1 : D0;
      3'd5: return (x < y)  ? D1 : D0;
      3'd6: return (x == y) ? D1 : D0;
      default: return D0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LAT; i++) begin
      m_v[i] = 1'b0; m_id[i] = 0; m_d[i] = '0; m_e[i] = 1'b0;
    end
    m_ptr = 0;
  endtask

  task automatic cyc_begin(input logic [N-1:0] v, input logic rr);
    logic [N-1:0] exp_rdy;
    @(negedge clock);
    req_valid  = v;
    resp_ready = rr;
    for (int i = 0; i < N; i++) begin
      req_op[3*i +: 3]  = op_r[i];
      req_a[64*i +: 64] = a_r[i];
      req_b[64*i +: 64] = b_r[i];
    end
    #1;
    adv = !m_v[LAT-1] || rr;
    g_w = -1;
    for (int k = 0; k < N; k++) begin
      if (g_w < 0 && v[(m_ptr + k) % N]) g_w = (m_ptr + k) % N;
    end
    exp_rdy = (adv && g_w >= 0) ? (N'(1) << g_w) : '0;
    chk("model_req_ready", 64'(req_ready), 64'(exp_rdy));
    chk("model_resp_valid", 64'(resp_valid), 64'(m_v[LAT-1]));
    if (m_v[LAT-1]) begin
      chk("model_resp_id", 64'(resp_id), 64'(m_id[LAT-1]));
      chk("model_resp_data", resp_data, m_d[LAT-1]);
      chk("model_resp_err", 64'(resp_err), 64'(m_e[LAT-1]));
    end
  endtask

  task automatic cyc_end();
    if (adv) begin
      for (int i = LAT-1; i > 0; i--) begin
        m_v[i] = m_v[i-1]; m_id[i] = m_id[i-1]; m_d[i] = m_d[i-1]; m_e[i] = m_e[i-1];
      end
      m_v[0] = (g_w >= 0);
      if (g_w >= 0) begin
        m_id[0] = g_w;
        m_d[0]  = ref_op(op_r[g_w], a_r[g_w], b_r[g_w]);
        m_e[0]  = (op_r[g_w] == 3'd7);
        m_ptr   = (g_w + 1) % N;
      end
    end
    @(posedge clock);
  endtask

  task automatic step(input logic [N-1:0] v, input logic rr);
    cyc_begin(v, rr);
    cyc_end();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_valid = '1;
    resp_ready = 1'b1;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    req_valid = '0;
    model_reset();
  endtask

  initial begin
    logic [63:0] held_d;
    logic [IW-1:0] held_id;

    pool[0] = D1; pool[1] = D2; pool[2] = D3; pool[3] = D0;
    pool[4] = DNAN; pool[5] = 64'hBFF8000000000000; pool[6] = 64'h3FE0000000000000;
    pool[7] = 64'h4202A05F20000000;

    vecs[0]  = '{3'd0, D1, D2, D3, 1'b0};
    vecs[1]  = '{3'd1, D1, D2, 64'hBFF0000000000000, 1'b0};
    vecs[2]  = '{3'd2, D2, D3, 64'h4018000000000000, 1'b0};
    vecs[3]  = '{3'd3, D1, D2, 64'h3FE0000000000000, 1'b0};
    vecs[4]  = '{3'd3, D1, D0, 64'h7FF0000000000000, 1'b0};
    vecs[5]  = '{3'd4, D2, D1, D1, 1'b0};
    vecs[6]  = '{3'd4, D1, D2, D0, 1'b0};
    vecs[7]  = '{3'd5, D1, D2, D1, 1'b0};
    vecs[8]  = '{3'd6, D2, D2, D1, 1'b0};
    vecs[9]  = '{3'd6, DNAN, DNAN, D0, 1'b0};
    vecs[10] = '{3'd5, DNAN, D1, D0, 1'b0};
    vecs[11] = '{3'd7, D2, D3, D0, 1'b1};

    for (int i = 0; i < N; i++) begin
      op_r[i] = 3'd0; a_r[i] = D0; b_r[i] = D0;
    end
    model_reset();
    do_reset();

    // Vector table: one request at a time, result expected LAT cycles later.
    for (int i = 0; i < 12; i++) begin
      int r;
      r = i % N;
      op_r[r] = vecs[i].op; a_r[r] = vecs[i].a; b_r[r] = vecs[i].b;
      cyc_begin(N'(1) << r, 1'b1);
      chk("vec_grant", 64'(req_ready), 64'(N'(1) << r));
      cyc_end();
      repeat (LAT-1) begin
        cyc_begin('0, 1'b1);
        chk("vec_early_valid", 64'(resp_valid), 64'd0);
        cyc_end();
      end
      cyc_begin('0, 1'b1);
      chk("vec_valid", 64'(resp_valid), 64'd1);
      chk("vec_id", 64'(resp_id), 64'(r));
      chk("vec_data", resp_data, vecs[i].data);
      chk("vec_err", 64'(resp_err), 64'(vecs[i].err));
      cyc_end();
    end

    // Round-robin with every requester asserting.
    do_reset();
    for (int i = 0; i < N; i++) begin
      op_r[i] = 3'd2; a_r[i] = D2; b_r[i] = D3;
    end
    for (int c = 0; c < 8; c++) begin
      cyc_begin('1, 1'b1);
      chk("rr_grant", 64'(req_ready), 64'(N'(1) << (c % N)));
      if (c >= LAT) begin
        chk("rr_id", 64'(resp_id), 64'((c - LAT) % N));
        chk("rr_data", resp_data, 64'h4018000000000000);
      end
      cyc_end();
    end

    // Backpressure: full pipeline held for five cycles, then drained.
    for (int c = 0; c < 5; c++) begin
      cyc_begin('1, 1'b0);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      chk("stall_resp_valid", 64'(resp_valid), 64'd1);
      if (c == 0) begin
        held_d = resp_data; held_id = resp_id;
      end else begin
        chk("stall_data_stable", resp_data, held_d);
        chk("stall_id_stable", 64'(resp_id), 64'(held_id));
      end
      cyc_end();
    end
    repeat (4) step('1, 1'b1);
    repeat (LAT + 2) step('0, 1'b1);

    // Reset with two results in flight.
    step('1, 1'b1);
    step('1, 1'b1);
    do_reset();
    cyc_begin(4'b1100, 1'b1);
    chk("post_reset_grant", 64'(req_ready), 64'b0100);
    cyc_end();
    repeat (LAT + 2) step('0, 1'b1);

    // Randomized traffic and backpressure.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        op_r[i] = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
        a_r[i]  = pool[$urandom_range(0, 7)];
        b_r[i]  = pool[$urandom_range(0, 7)];
      end
      step(N'($urandom), $urandom_range(0, 3) != 0);
    end
    repeat (LAT + 2) step('0, 1'b1);

`ifdef BBF_ARB_STATS_EN
    do_reset();
    repeat (10) step(4'b0010, 1'b1);
    repeat (3) step(4'b0100, 1'b1);
    #1;
    chk("stat_req0", 64'(stat_grants[31:0]), 64'd0);
    chk("stat_req1", 64'(stat_grants[63:32]), 64'd10);
    chk("stat_req2", 64'(stat_grants[95:64]), 64'd3);
    chk("stat_req3", 64'(stat_grants[127:96]), 64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
